// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - multi-cycle data-memory responder with stall and one-cycle ack
// Optional access-error checking enabled by defining DATA_MEM_RESPONDER_ERR_EN.
module data_mem_responder #(
    parameter int DEPTH_LOG2 = 5,
    parameter int LATENCY    = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        busy_o,
    output logic        err_o
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

    state_t                  state, state_nx;
    logic [7:0]              cnt;
    logic                    we_q;
    logic [DEPTH_LOG2-1:0]   idx_q;
    logic [31:0]             wdata_q;
    logic                    err_q;
    logic [31:0]             mem [0:(1<<DEPTH_LOG2)-1];

    logic                    req_err;
    logic                    accept;
    logic                    do_acc;
    logic                    acc_we;
    logic [DEPTH_LOG2-1:0]   acc_idx;
    logic [31:0]             acc_wdata;
    logic                    acc_err;

`ifdef DATA_MEM_RESPONDER_ERR_EN
    assign req_err = (addr_i[1:0] != 2'b00) || (|addr_i[31:DEPTH_LOG2+2]);
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_i[31:DEPTH_LOG2+2], addr_i[1:0]};
    assign req_err = 1'b0;
`endif

    assign accept = (state == IDLE) && req_i;

    // With LATENCY=1 there is no WAIT cycle, so the access happens at acceptance using live inputs.
    assign do_acc = (accept && (LATENCY == 1)) || ((state == WAIT) && (cnt == 8'd1));

    always_comb begin
        acc_we    = we_q;
        acc_idx   = idx_q;
        acc_wdata = wdata_q;
        acc_err   = err_q;
        if (state == IDLE) begin
            acc_we    = we_i;
            acc_idx   = addr_i[DEPTH_LOG2+1:2];
            acc_wdata = wdata_i;
            acc_err   = req_err;
        end
    end

    always_comb begin
        state_nx = state;
        busy_o   = 1'b0;
        case (state)
            IDLE: begin
                if (req_i) begin
                    busy_o   = 1'b1;
                    state_nx = (LATENCY == 1) ? DONE : WAIT;
                end
            end
            WAIT: begin
                busy_o = 1'b1;
                if (cnt == 8'd1) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign ack_o = (state == DONE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            err_q   <= 1'b0;
            rdata_o <= 32'd0;
            err_o   <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                we_q    <= we_i;
                idx_q   <= addr_i[DEPTH_LOG2+1:2];
                wdata_q <= wdata_i;
                err_q   <= req_err;
                cnt     <= LAT_M1;
            end else if (state == WAIT) begin
                cnt <= cnt - 8'd1;
            end
            if (do_acc) begin
                if (!acc_we) rdata_o <= acc_err ? 32'd0 : mem[acc_idx];
                err_o <= acc_err;
            end else if (state == DONE) begin
                err_o <= 1'b0;
            end
        end
    end

    // Reset wins over a pending store so an aborted access never reaches the array.
    always_ff @(posedge clk_i) begin
        if (!rst_i && do_acc && acc_we && !acc_err) mem[acc_idx] <= acc_wdata;
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench for data_mem_responder
module tb_data_mem_responder;

`ifdef DATA_MEM_RESPONDER_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0, we = 1'b0;
    logic [31:0] addr = 32'd0, wdata = 32'd0;
    logic        ack, busy, err;
    logic [31:0] rdata;
    logic        req1 = 1'b0, we1 = 1'b0;
    logic [31:0] addr1 = 32'd0, wdata1 = 32'd0;
    logic        ack1, busy1, err1;
    logic [31:0] rdata1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_LOG2(5), .LATENCY(4)) u_lat4 (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .ack_o(ack), .rdata_o(rdata), .busy_o(busy), .err_o(err)
    );

    data_mem_responder #(.DEPTH_LOG2(5), .LATENCY(1)) u_lat1 (
        .clk_i(clk), .rst_i(rst), .req_i(req1), .we_i(we1), .addr_i(addr1), .wdata_i(wdata1),
        .ack_o(ack1), .rdata_o(rdata1), .busy_o(busy1), .err_o(err1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One request on the LATENCY=4 instance; optionally alters addr/wdata once the request is in WAIT.
    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic chg, input logic [31:0] a2, input logic [31:0] d2,
                          output int lat, output logic [31:0] rd, output logic e,
                          output logic [7:0] bh);
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d;
        lat = -1; rd = 32'd0; e = 1'b0; bh = 8'd0;
        #1;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk);
            if (k < 8) bh[k] = busy;
            if (ack) begin
                lat = k; rd = rdata; e = err;
                break;
            end
            if (k == 1 && chg) begin
                addr = a2; wdata = d2;
            end
        end
        req = 1'b0;
        if (lat < 0) check("ack_timeout", 32'd0, 32'd1);
    endtask

    int          lat;
    logic [31:0] rd;
    logic        e;
    logic [7:0]  bh;
    logic [5:0]  ah1, bh1;
    int          nack;

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ack", ack, 0);
        check("rst_rdata", rdata, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) access(1'b1, 32'(i * 4), 32'd0, 1'b0, 0, 0, lat, rd, e, bh);
        access(1'b1, 32'h04, 32'h11111111, 1'b0, 0, 0, lat, rd, e, bh);

        access(1'b1, 32'h08, 32'hDEADBEEF, 1'b0, 0, 0, lat, rd, e, bh);
        check("st_latency", lat, 4);
        check("st_busy_0_3", {28'd0, bh[3:0]}, 32'hF);
        check("st_busy_at_ack", bh[4], 0);
        check("st_err", e, 0);
        check("st_rdata_kept", rd, 0);

        access(1'b0, 32'h08, 0, 1'b0, 0, 0, lat, rd, e, bh);
        check("ld08_rdata", rd, 32'hDEADBEEF);
        check("ld08_latency", lat, 4);
        repeat (3) @(negedge clk);
        check("ld08_held", rdata, 32'hDEADBEEF);
        check("idle_busy", busy, 0);

        access(1'b1, 32'h08, 32'hCAFEF00D, 1'b1, 32'h10, 32'h12345678, lat, rd, e, bh);
        check("st_after_ld_rdata", rd, 32'hDEADBEEF);
        access(1'b0, 32'h10, 0, 1'b0, 0, 0, lat, rd, e, bh);
        check("ld10_untouched", rd, 32'h0);
        access(1'b0, 32'h0C, 0, 1'b0, 0, 0, lat, rd, e, bh);
        check("ld0c_zero", rd, 32'h0);
        access(1'b0, 32'h08, 0, 1'b0, 0, 0, lat, rd, e, bh);
        check("ld08_latched_data", rd, 32'hCAFEF00D);

        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h04; wdata = 32'h99999999;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1; req = 1'b0;
        @(negedge clk);
        check("abort_ack", ack, 0);
        check("abort_busy", busy, 0);
        check("abort_rdata", rdata, 0);
        check("abort_err", err, 0);
        rst = 1'b0;
        nack = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack) nack++;
        end
        check("abort_no_ack", nack, 0);
        access(1'b0, 32'h04, 0, 1'b0, 0, 0, lat, rd, e, bh);
        check("abort_old_value", rd, 32'h11111111);

        access(1'b1, 32'h02, 32'h77777777, 1'b0, 0, 0, lat, rd, e, bh);
        check("st02_err", e, ERR_EN);
        check("st02_latency", lat, 4);
        access(1'b1, 32'h80, 32'h55AA55AA, 1'b0, 0, 0, lat, rd, e, bh);
        check("st80_err", e, ERR_EN);
        @(negedge clk);
        check("err_cleared", err, 0);
        access(1'b0, 32'h00, 0, 1'b0, 0, 0, lat, rd, e, bh);
        check("ld00_rdata", rd, ERR_EN ? 32'h0 : 32'h55AA55AA);
        check("ld00_err", e, 0);
        access(1'b0, 32'h80, 0, 1'b0, 0, 0, lat, rd, e, bh);
        check("ld80_rdata", rd, ERR_EN ? 32'h0 : 32'h55AA55AA);
        check("ld80_err", e, ERR_EN);

        @(negedge clk);
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h14; wdata1 = 32'hA5A5A5A5;
        @(negedge clk);
        check("l1_st_ack", ack1, 1);
        req1 = 1'b0;
        @(negedge clk);
        req1 = 1'b1; we1 = 1'b0;
        #1;
        ah1 = '0; bh1 = '0;
        ah1[0] = ack1; bh1[0] = busy1;
        for (int k = 1; k < 6; k++) begin
            @(negedge clk);
            ah1[k] = ack1; bh1[k] = busy1;
            if (ack1) check("l1_ld_rdata", rdata1, 32'hA5A5A5A5);
            if (k == 3) req1 = 1'b0;
        end
        check("l1_ack_pattern", {26'd0, ah1}, 32'b001010);
        check("l1_busy_pattern", {26'd0, bh1}, 32'b000101);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
